// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory request arbiter.
// Holds the controller state encoding and the pointer-width helper.
package mem_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_REQ    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2
    } arb_state_t;

    // Width of a requester index; never zero so a single requester still gets a 1-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and memory-side handshake bundle of the arbiter.
// slave: arbiter view; master: requesters plus memory driving the arbiter.
interface mem_req_arbiter_if #(
    parameter int WIDTH      = mem_pkg::DEF_WIDTH,
    parameter int ADDR_WIDTH = mem_pkg::DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = mem_pkg::DEF_NUM_REQ
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ-1:0]            req_wr_rd_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ*WIDTH-1:0]      req_wr_data_i;
    logic [NUM_REQ-1:0]            rsp_valid_o;
    logic [WIDTH-1:0]              rsp_rd_data_o;
    logic                          mem_valid_o;
    logic                          mem_ready_i;
    logic                          mem_wr_rd_o;
    logic [ADDR_WIDTH-1:0]         mem_addr_o;
    logic [WIDTH-1:0]              mem_wr_data_o;
    logic [WIDTH-1:0]              mem_rd_data_i;

    modport slave (
        input  req_valid_i, req_wr_rd_i, req_addr_i, req_wr_data_i,
        input  mem_ready_i, mem_rd_data_i,
        output req_ready_o, rsp_valid_o, rsp_rd_data_o,
        output mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o
    );

    modport master (
        output req_valid_i, req_wr_rd_i, req_addr_i, req_wr_data_i,
        output mem_ready_i, mem_rd_data_i,
        input  req_ready_o, rsp_valid_o, rsp_rd_data_o,
        input  mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request searching upward from last_i+1, wrapping.
// Latency: combinational, no state.
// Backpressure: none; grant is one-hot or zero when no request is set.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int PTR_W  = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic             found;
    int               cand;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        cand  = 0;
        idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_i) + off) % NUM_REQ;
            idx  = PTR_W'(cand);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates NUM_REQ requesters onto one single-port memory, one transaction at a time.
// Latency: write 2 cycles (grant, issue); read 3 cycles plus a response pulse the cycle after.
// Backpressure: mem_ready_i low holds the issue phase; requesters wait on req_ready_o.
module mem_req_arbiter
    import mem_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic               clk,
    input  logic               rst,
    mem_req_arbiter_if.slave   bus
);

    localparam int               PTR_W    = ptr_width(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(NUM_REQ - 1);

    arb_state_t             state_q, state_d;
    logic [PTR_W-1:0]       last_grant_q, last_grant_d;
    logic [PTR_W-1:0]       gnt_idx;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     owner_q, owner_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic                   wr_rd_q, wr_rd_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]       wr_data_q, wr_data_d;
    logic [WIDTH-1:0]       rsp_rd_data_q, rsp_rd_data_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i  (bus.req_valid_i),
        .last_i (last_grant_q),
        .gnt_o  (grant)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_idx = PTR_W'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        wr_rd_d       = wr_rd_q;
        addr_d        = addr_q;
        wr_data_d     = wr_data_q;
        rsp_rd_data_d = rsp_rd_data_q;
        rsp_valid_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    owner_d      = grant;
                    last_grant_d = gnt_idx;
                    wr_rd_d      = bus.req_wr_rd_i[gnt_idx];
                    addr_d       = bus.req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wr_data_d    = bus.req_wr_data_i[gnt_idx*WIDTH +: WIDTH];
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_ready_i) begin
                    state_d = wr_rd_q ? ST_IDLE : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                // Memory read data is valid this cycle; the requester sees it one cycle later.
                rsp_rd_data_d = bus.mem_rd_data_i;
                rsp_valid_d   = owner_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= LAST_RST;
            owner_q       <= '0;
            wr_rd_q       <= 1'b0;
            addr_q        <= '0;
            wr_data_q     <= '0;
            rsp_valid_q   <= '0;
            rsp_rd_data_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            wr_rd_q       <= wr_rd_d;
            addr_q        <= addr_d;
            wr_data_q     <= wr_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rd_data_q <= rsp_rd_data_d;
        end
    end

    // Grant is combinational off the request vector, so reset must mask it explicitly.
    assign bus.req_ready_o   = (rst && state_q == ST_IDLE) ? grant : '0;
    assign bus.mem_valid_o   = (state_q == ST_ISSUE);
    assign bus.mem_wr_rd_o   = wr_rd_q;
    assign bus.mem_addr_o    = addr_q;
    assign bus.mem_wr_data_o = wr_data_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_rd_data_o = rsp_rd_data_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: transaction-level model plus directed scenarios.
module tb_mem_req_arbiter;
    import mem_pkg::*;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_req_arbiter_if #(.WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) bus ();

    mem_req_arbiter #(.WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: accepts writes on handshake, returns read data the following cycle.
    bit [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (rst && bus.mem_valid_o && bus.mem_ready_i) begin
            if (bus.mem_wr_rd_o) mem[bus.mem_addr_o] <= bus.mem_wr_data_o;
            else                 bus.mem_rd_data_i   <= mem[bus.mem_addr_o];
        end
    end

    // Transaction model: at most one request in flight, round-robin admission.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N] === 1'b1) return (last + k) % N;
        end
        return -1;
    endfunction

    bit          m_busy, m_accepted, m_pulse, m_wr;
    int          m_last, m_req, m_rsp_req, m_pick;
    bit [AW-1:0] m_addr;
    bit [DW-1:0] m_data, m_rsp_data;
    bit [DW-1:0] shadow [16];

    always_comb m_pick = rr_pick(bus.req_valid_i, m_last);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy     <= 1'b0;
            m_accepted <= 1'b0;
            m_pulse    <= 1'b0;
            m_last     <= N - 1;
            m_rsp_data <= '0;
        end else begin
            m_pulse <= 1'b0;
            if (!m_busy) begin
                if (m_pick >= 0) begin
                    m_busy <= 1'b1;
                    m_req  <= m_pick;
                    m_last <= m_pick;
                    m_wr   <= bus.req_wr_rd_i[m_pick];
                    m_addr <= bus.req_addr_i[m_pick*AW +: AW];
                    m_data <= bus.req_wr_data_i[m_pick*DW +: DW];
                end
            end else if (!m_accepted) begin
                if (bus.mem_ready_i) begin
                    if (m_wr) begin
                        shadow[m_addr] <= m_data;
                        m_busy         <= 1'b0;
                    end else begin
                        m_accepted <= 1'b1;
                    end
                end
            end else begin
                m_rsp_data <= shadow[m_addr];
                m_rsp_req  <= m_req;
                m_pulse    <= 1'b1;
                m_busy     <= 1'b0;
                m_accepted <= 1'b0;
            end
        end
    end

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    logic [N-1:0]  acc_mask = '0;
    logic [N-1:0]  exp_ready, exp_rv;
    logic          exp_mv;
    int            grant_log [$];
    int            rsp_log [$];
    logic [DW-1:0] rsp_dlog [$];

    initial begin
        forever begin
            @(negedge clk);
            exp_ready = (rst && !m_busy && m_pick >= 0) ? (N'(1) << m_pick) : '0;
            exp_mv    = rst && m_busy && !m_accepted;
            exp_rv    = (rst && m_pulse) ? (N'(1) << m_rsp_req) : '0;
            check("req_ready_o", bus.req_ready_o, exp_ready);
            check("mem_valid_o", bus.mem_valid_o, exp_mv);
            if (exp_mv) begin
                check("mem_wr_rd_o", bus.mem_wr_rd_o, m_wr);
                check("mem_addr_o", bus.mem_addr_o, m_addr);
                check("mem_wr_data_o", bus.mem_wr_data_o, m_data);
            end
            check("rsp_valid_o", bus.rsp_valid_o, exp_rv);
            check("rsp_rd_data_o", bus.rsp_rd_data_o, m_rsp_data);
            acc_mask = bus.req_ready_o & bus.req_valid_i;
            if (bus.req_ready_o != '0) grant_log.push_back(oh_idx(bus.req_ready_o));
            if (bus.rsp_valid_o != '0) begin
                rsp_log.push_back(oh_idx(bus.rsp_valid_o));
                rsp_dlog.push_back(bus.rsp_rd_data_o);
            end
        end
    end

    // Inputs change only just after a rising edge; granted requesters drop valid.
    task automatic step();
        @(posedge clk);
        #1;
        bus.req_valid_i &= ~acc_mask;
    endtask

    task automatic post(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid_i[i]            = 1'b1;
        bus.req_wr_rd_i[i]            = wr;
        bus.req_addr_i[i*AW +: AW]    = a;
        bus.req_wr_data_i[i*DW +: DW] = d;
    endtask

    task automatic wait_granted(input int i, input string name, output int cycles);
        cycles = 0;
        while (bus.req_valid_i[i] && cycles < 40) begin
            step();
            cycles++;
        end
        if (bus.req_valid_i[i]) check({name, "_grant_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_quiet();
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 80) begin
            step();
            n++;
            if (bus.req_valid_i == '0 && !bus.mem_valid_o && bus.rsp_valid_o == '0) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) check("quiet_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_rsp(input string name, input logic [N-1:0] ev, input logic [DW-1:0] ed);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.rsp_valid_o == '0 && n < 20);
        check({name, "_rsp_valid"}, bus.rsp_valid_o, ev);
        check({name, "_rsp_data"}, bus.rsp_rd_data_o, ed);
        step();
    endtask

    task automatic check_grant(input string name, input int idx, input int exp);
        int act;
        act = (idx < grant_log.size()) ? grant_log[idx] : -1;
        check(name, act, exp);
    endtask

    task automatic check_rsp(input string name, input int idx, input int exp_req, input logic [DW-1:0] exp_d);
        int            act;
        logic [DW-1:0] actd;
        act  = (idx < rsp_log.size()) ? rsp_log[idx] : -1;
        actd = (idx < rsp_dlog.size()) ? rsp_dlog[idx] : 'x;
        check({name, "_req"}, act, exp_req);
        check({name, "_data"}, actd, exp_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, rbase, cyc;
        bus.req_valid_i   = '0;
        bus.req_wr_rd_i   = '0;
        bus.req_addr_i    = '0;
        bus.req_wr_data_i = '0;
        bus.mem_ready_i   = 1'b1;
        rst               = 1'b0;
        repeat (2) @(posedge clk);
        bus.req_valid_i = '1;
        @(negedge clk);
        check("rst_req_ready", bus.req_ready_o, 3'b000);
        check("rst_mem_valid", bus.mem_valid_o, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid_o, 3'b000);
        check("rst_rsp_data", bus.rsp_rd_data_o, 16'h0000);
        check("rst_mem_addr", {bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wr_data_o}, 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid_i = '0;
        rst = 1'b1;

        // Requester 1 preloads address 3; pointer 2 after reset, so search visits 0 then 1.
        base = grant_log.size();
        post(1, 1'b1, 4'd3, 16'h1234);
        wait_granted(1, "pre", cyc);
        check_grant("pre_grant", base, 1);

        // Requester 0 write then read back address 5.
        base = grant_log.size();
        post(0, 1'b1, 4'd5, 16'hABCD);
        wait_granted(0, "t1w", cyc);
        post(0, 1'b0, 4'd5, 16'h0000);
        wait_granted(0, "t1r", cyc);
        wait_rsp("t1", 3'b001, 16'hABCD);
        check_grant("t1_grant_w", base, 0);
        check_grant("t1_grant_r", base + 1, 0);

        // After a grant to 0, a lone requester 2 wins on the very next idle cycle.
        base = grant_log.size();
        post(2, 1'b1, 4'd7, 16'h5678);
        wait_granted(2, "t4", cyc);
        check("t4_latency", cyc, 1);
        check_grant("t4_grant", base, 2);
        wait_quiet();

        // All three read together, requester 0 re-requests once served.
        base  = grant_log.size();
        rbase = rsp_log.size();
        post(0, 1'b0, 4'd5, 16'h0);
        post(1, 1'b0, 4'd3, 16'h0);
        post(2, 1'b0, 4'd7, 16'h0);
        wait_granted(0, "t2", cyc);
        post(0, 1'b0, 4'd7, 16'h0);
        wait_quiet();
        check_grant("t2_grant0", base, 0);
        check_grant("t2_grant1", base + 1, 1);
        check_grant("t2_grant2", base + 2, 2);
        check_grant("t2_grant3", base + 3, 0);
        check_rsp("t2_rsp0", rbase, 0, 16'hABCD);
        check_rsp("t2_rsp1", rbase + 1, 1, 16'h1234);
        check_rsp("t2_rsp2", rbase + 2, 2, 16'h5678);
        check_rsp("t2_rsp3", rbase + 3, 0, 16'h5678);

        // Memory stalls four cycles while another requester waits.
        bus.mem_ready_i = 1'b0;
        post(1, 1'b1, 4'd10, 16'hBEEF);
        wait_granted(1, "t3", cyc);
        post(0, 1'b0, 4'd10, 16'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_mem_valid", bus.mem_valid_o, 1'b1);
            check("t3_mem_wr_rd", bus.mem_wr_rd_o, 1'b1);
            check("t3_mem_addr", bus.mem_addr_o, 4'd10);
            check("t3_mem_data", bus.mem_wr_data_o, 16'hBEEF);
            check("t3_req_ready", bus.req_ready_o, 3'b000);
        end
        step();
        bus.mem_ready_i = 1'b1;
        wait_granted(0, "t3r", cyc);
        wait_rsp("t3", 3'b001, 16'hBEEF);
        wait_quiet();

        // Reset lands mid-issue of a read: everything clears, the read is lost.
        bus.mem_ready_i = 1'b0;
        post(1, 1'b0, 4'd3, 16'h0);
        wait_granted(1, "t5", cyc);
        post(0, 1'b0, 4'd5, 16'h0);
        post(2, 1'b0, 4'd7, 16'h0);
        @(negedge clk);
        check("t5_in_issue", bus.mem_valid_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_ready", bus.req_ready_o, 3'b000);
        check("t5_rst_mem_valid", bus.mem_valid_o, 1'b0);
        check("t5_rst_mem_fields", {bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wr_data_o}, 32'h0);
        check("t5_rst_rsp_valid", bus.rsp_valid_o, 3'b000);
        check("t5_rst_rsp_data", bus.rsp_rd_data_o, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.mem_ready_i = 1'b1;
        base  = grant_log.size();
        rbase = rsp_log.size();
        wait_granted(0, "t5r", cyc);
        wait_quiet();
        check_grant("t5_first_grant", base, 0);
        check_grant("t5_second_grant", base + 1, 2);
        check("t5_rsp_count", rsp_log.size() - rbase, 2);
        check_rsp("t5_rsp0", rbase, 0, 16'hABCD);
        check_rsp("t5_rsp1", rbase + 1, 2, 16'h5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
